// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Holds the FSM state encoding, the port-select constants, the default memory
// latency and the latency counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  localparam int MEM_LAT_DEF = 4;

  // Latency range 1..15 means MEM_LAT-1 always fits in 4 bits.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the unified memory.
// Ports:
//   I-port : i_req, i_addr -> i_ack, i_rdata
//   D-port : d_req, d_wr, d_addr, d_wdata -> d_ack, d_rdata
//   memory : mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata
//   status : busy
// Modports: slave = arbiter view, master = CPU/memory side view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/lat_counter.sv
// Memory latency down-counter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over dec)
//   dec        : decrement by one, saturating at zero
//   load_val   : value to load
//   zero       : count is zero
module lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the instruction
// fetch port (read-only) and the load/store port. Accesses are serialised
// IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack) -> IDLE.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   bus        : mem_arbiter_if.slave (CPU I/D ports, memory port, busy)
// Build option:
//   MEM_ARB_RR_EN defined   -> round-robin on simultaneous requests
//   MEM_ARB_RR_EN undefined -> fixed priority, D-port over I-port
//
// state  | meaning
// IDLE   | waiting for a request; winner chosen and latched on the sample edge
// ACCESS | memory enabled, latency counting down, mem_* held stable
// RESP   | one-cycle ack to the winner, read data already registered
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              pick;

  lat_counter u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero)
  );

  // sel_q records the port of the current/last access; in round-robin mode
  // it doubles as the last-granted register.
`ifdef MEM_ARB_RR_EN
  assign pick = (bus.d_req && bus.i_req) ? (sel_q == SEL_I) : bus.d_req;
`else
  assign pick = bus.d_req;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.d_req || bus.i_req) begin
          sel_d    = pick ? SEL_D : SEL_I;
          mem_en_d = 1'b1;
          cnt_load = 1'b1;
          state_d  = ACCESS;
          if (pick) begin
            mem_wr_d    = bus.d_wr;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_wr_d    = 1'b0;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ACCESS: begin
        if (cnt_zero) begin
          mem_en_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = RESP;
          if (sel_q == SEL_D) begin
            d_ack_d = 1'b1;
            if (!mem_wr_q) d_rdata_d = bus.mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= SEL_I;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with latency 4 and one with latency 1.
// A transaction-timeline model predicts acks, busy, memory strobes and read
// data every cycle; directed sequences add hand-computed literal checks.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if b0 ();
  mem_arbiter_if b1 ();

  mem_arbiter #(.MEM_LAT(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_arbiter #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // requester drive, index = instance
  logic        i_req [2];
  logic        d_req [2];
  logic        d_wr  [2];
  logic [15:0] i_addr[2];
  logic [15:0] d_addr[2];
  logic [15:0] d_wdata[2];

  assign b0.i_req = i_req[0];  assign b1.i_req = i_req[1];
  assign b0.i_addr = i_addr[0]; assign b1.i_addr = i_addr[1];
  assign b0.d_req = d_req[0];  assign b1.d_req = d_req[1];
  assign b0.d_wr = d_wr[0];    assign b1.d_wr = d_wr[1];
  assign b0.d_addr = d_addr[0]; assign b1.d_addr = d_addr[1];
  assign b0.d_wdata = d_wdata[0]; assign b1.d_wdata = d_wdata[1];

  logic        i_ack_w[2], d_ack_w[2], busy_w[2], mem_en_w[2], mem_wr_w[2];
  logic [15:0] i_rdata_w[2], d_rdata_w[2], mem_addr_w[2], mem_wdata_w[2];

  assign i_ack_w[0] = b0.i_ack;         assign i_ack_w[1] = b1.i_ack;
  assign d_ack_w[0] = b0.d_ack;         assign d_ack_w[1] = b1.d_ack;
  assign busy_w[0] = b0.busy;           assign busy_w[1] = b1.busy;
  assign mem_en_w[0] = b0.mem_en;       assign mem_en_w[1] = b1.mem_en;
  assign mem_wr_w[0] = b0.mem_wr;       assign mem_wr_w[1] = b1.mem_wr;
  assign i_rdata_w[0] = b0.i_rdata;     assign i_rdata_w[1] = b1.i_rdata;
  assign d_rdata_w[0] = b0.d_rdata;     assign d_rdata_w[1] = b1.d_rdata;
  assign mem_addr_w[0] = b0.mem_addr;   assign mem_addr_w[1] = b1.mem_addr;
  assign mem_wdata_w[0] = b0.mem_wdata; assign mem_wdata_w[1] = b1.mem_wdata;

  // memory: word i holds 16'h5000+i, word 0x20 (byte 0x0040) holds BEEF
  logic [15:0] mem [2][256];
  assign b0.mem_rdata = mem[0][b0.mem_addr[8:1]];
  assign b1.mem_rdata = mem[1][b1.mem_addr[8:1]];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) mem[k][i] = 16'h5000 + 16'(i);
    mem[0][8'h20] = 16'hBEEF;
    forever begin
      @(posedge clk);
      if (b0.mem_en && b0.mem_wr) mem[0][b0.mem_addr[8:1]] = b0.mem_wdata;
      if (b1.mem_en && b1.mem_wr) mem[1][b1.mem_addr[8:1]] = b1.mem_wdata;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // ---------------- transaction-timeline model ----------------
  // An access sampled at edge E owns the memory after edges E..E+L-1, acks
  // after edge E+L, and the next request can be sampled at edge E+L+2.
  int          edge_n = 0;
  int          samp[2];
  int          free_e[2];
  bit          own_d[2], own_wr[2], last_d[2];
  logic [15:0] own_addr[2], own_wdata[2];
  logic [15:0] e_i_rdata[2], e_d_rdata[2];
  logic [15:0] mdl_mem[2][256];
  bit          mdl_init = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    if (!mdl_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) mdl_mem[k][i] = 16'h5000 + 16'(i);
      mdl_mem[0][8'h20] = 16'hBEEF;
      mdl_init = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        samp[k] = -1000; free_e[k] = 0; last_d[k] = 1'b0;
        e_i_rdata[k] = '0; e_d_rdata[k] = '0; own_wr[k] = 1'b0; own_d[k] = 1'b0;
      end else begin
        if (edge_n == samp[k] + lat(k) && !own_wr[k]) begin
          if (own_d[k]) e_d_rdata[k] = mdl_mem[k][own_addr[k][8:1]];
          else          e_i_rdata[k] = mdl_mem[k][own_addr[k][8:1]];
        end
        if (edge_n >= free_e[k] && (i_req[k] || d_req[k])) begin
          bit pd;
`ifdef MEM_ARB_RR_EN
          pd = (i_req[k] && d_req[k]) ? !last_d[k] : d_req[k];
`else
          pd = d_req[k];
`endif
          own_d[k]     = pd;
          own_wr[k]    = pd && d_wr[k];
          own_addr[k]  = pd ? d_addr[k] : i_addr[k];
          own_wdata[k] = d_wdata[k];
          samp[k]      = edge_n;
          free_e[k]    = edge_n + lat(k) + 2;
          last_d[k]    = pd;
          if (own_wr[k]) mdl_mem[k][own_addr[k][8:1]] = own_wdata[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        int ph;
        bit acc, rsp;
        ph  = edge_n - samp[k];
        acc = (ph >= 0) && (ph < lat(k));
        rsp = (ph == lat(k));
        chk($sformatf("u%0d.busy", k), busy_w[k], acc || rsp);
        chk($sformatf("u%0d.mem_en", k), mem_en_w[k], acc);
        chk($sformatf("u%0d.mem_wr", k), mem_wr_w[k], acc && own_wr[k]);
        chk($sformatf("u%0d.i_ack", k), i_ack_w[k], rsp && !own_d[k]);
        chk($sformatf("u%0d.d_ack", k), d_ack_w[k], rsp && own_d[k]);
        chk($sformatf("u%0d.i_rdata", k), i_rdata_w[k], e_i_rdata[k]);
        chk($sformatf("u%0d.d_rdata", k), d_rdata_w[k], e_d_rdata[k]);
        if (acc) chk($sformatf("u%0d.mem_addr", k), mem_addr_w[k], own_addr[k]);
        if (acc && own_wr[k]) chk($sformatf("u%0d.mem_wdata", k), mem_wdata_w[k], own_wdata[k]);
      end
    end
  end

  // ---------------- requester ----------------
  // Raises the request after the next edge, holds it until the ack and drops
  // it on the ack edge. n = cycles from the request cycle to the ack cycle.
  task automatic xfer(input int k, input bit is_d, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, output int n, output logic [15:0] rd);
    bit done;
    @(posedge clk); #1;
    if (is_d) begin
      d_req[k] = 1'b1; d_wr[k] = wr; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    n = 0; rd = '0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (is_d ? d_ack_w[k] : i_ack_w[k]) begin
        rd = is_d ? d_rdata_w[k] : i_rdata_w[k];
        done = 1'b1;
      end else begin
        n++;
        if (n > 60) begin
          n_checks++;
          $display("FAIL u%0d ack_timeout: no ack after %0d cycles, required within 60", k, n);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    if (is_d) d_req[k] = 1'b0;
    else      i_req[k] = 1'b0;
  endtask

  initial begin
    int          n, n2;
    logic [15:0] rd, rd2;
    logic [15:0] addr_seen;
    int          acks[$];
    bit          got;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 0; d_req[k] = 0; d_wr[k] = 0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of an access
    @(posedge clk); #1;
    i_req[0] = 1'b1; i_addr[0] = 16'h0030;
    repeat (3) @(negedge clk);
    chk("pre_reset.mem_en", mem_en_w[0], 1);
    #2 rst_n = 1'b0; i_req[0] = 1'b0;
    #1;
    chk("rst.busy", busy_w[0], 0);
    chk("rst.mem_en", mem_en_w[0], 0);
    chk("rst.mem_addr", mem_addr_w[0], 0);
    chk("rst.i_ack", i_ack_w[0], 0);
    chk("rst.i_rdata", i_rdata_w[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // fetch after reset
    xfer(0, 0, 0, 16'h0010, 16'h0, n, rd);
    chk("fetch.lat", n, 5);
    chk("fetch.rdata", rd, 16'h5008);

    // load, with d_addr changed while the access is in flight
    fork
      xfer(0, 1, 0, 16'h0040, 16'h0, n, rd);
      begin
        @(posedge clk); #1;
        repeat (2) @(negedge clk);
        d_addr[0] = 16'h00F0;
        @(negedge clk);
        chk("load.addr_held", mem_addr_w[0], 16'h0040);
        chk("load.no_i_ack", i_ack_w[0], 0);
      end
    join
    chk("load.lat", n, 5);
    chk("load.rdata", rd, 16'hBEEF);

    // store then load back
    xfer(0, 1, 1, 16'h0080, 16'h1234, n, rd);
    chk("store.lat", n, 5);
    chk("store.d_rdata_kept", d_rdata_w[0], 16'hBEEF);
    xfer(0, 1, 0, 16'h0080, 16'h0, n, rd);
    chk("reload.rdata", rd, 16'h1234);

    // fetch request dropped mid-access still completes
    @(posedge clk); #1;
    i_req[0] = 1'b1; i_addr[0] = 16'h0020;
    @(posedge clk); #1;
    i_req[0] = 1'b0; i_addr[0] = 16'h0060;
    n = 0; got = 1'b0; addr_seen = '0;
    while (!got && n <= 20) begin
      @(negedge clk);
      if (n == 0) addr_seen = mem_addr_w[0];
      if (i_ack_w[0]) got = 1'b1;
      else n++;
    end
    chk("drop.addr_held", addr_seen, 16'h0020);
    chk("drop.ack_cycles", n, 4);
    chk("drop.rdata", i_rdata_w[0], 16'h5010);
    @(posedge clk); #1;

    // collision after an I access: D wins in both arbitration modes
    xfer(0, 0, 0, 16'h0002, 16'h0, n, rd);
    fork
      xfer(0, 1, 0, 16'h0004, 16'h0, n, rd);
      xfer(0, 0, 0, 16'h0006, 16'h0, n2, rd2);
    join
    chk("coll1.d_lat", n, 5);
    chk("coll1.i_lat", n2, 11);
    chk("coll1.d_rdata", rd, 16'h5002);
    chk("coll1.i_rdata", rd2, 16'h5003);

    // collision after a D access: round-robin flips the order
    xfer(0, 1, 0, 16'h0008, 16'h0, n, rd);
    fork
      xfer(0, 1, 0, 16'h000A, 16'h0, n, rd);
      xfer(0, 0, 0, 16'h000C, 16'h0, n2, rd2);
    join
`ifdef MEM_ARB_RR_EN
    chk("coll2.d_lat", n, 11);
    chk("coll2.i_lat", n2, 5);
`else
    chk("coll2.d_lat", n, 5);
    chk("coll2.i_lat", n2, 11);
`endif
    chk("coll2.d_rdata", rd, 16'h5005);
    chk("coll2.i_rdata", rd2, 16'h5006);

    // latency 1 instance
    xfer(1, 0, 0, 16'h0010, 16'h0, n, rd);
    chk("lat1.lat", n, 2);
    chk("lat1.rdata", rd, 16'h5008);

    // held fetch request: one ack every 3 cycles
    @(posedge clk); #1;
    i_req[1] = 1'b1; i_addr[1] = 16'h0012;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i_ack_w[1]) acks.push_back(c);
    end
    @(posedge clk); #1;
    i_req[1] = 1'b0;
    chk("b2b.count", acks.size(), 4);
    if (acks.size() > 0) chk("b2b.first", acks[0], 2);
    for (int j = 1; j < acks.size(); j++) chk($sformatf("b2b.gap%0d", j), acks[j] - acks[j-1], 3);

    repeat (6) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required under 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
